// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the pipelined RV32I core. Owns the program
// counter, addresses the combinational instruction memory and captures the
// returned word into the IF/ID pipeline register.
//
// Per-edge priority: rst > flush > stall > advance.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             hold pc and IF/ID (load-use hazard)
//   flush             redirect pc to branch_target, inject a bubble into IF/ID
//   branch_target     redirect address, sampled only while flush=1
//   imem_addr         byte address to instruction memory (= pc)
//   imem_data         instruction word returned for imem_addr
//   if_id_pc/_pc4     pc (and pc+4) of the instruction held in IF/ID
//   if_id_instr       instruction held in IF/ID
//   if_id_valid       1 = real instruction, 0 = bubble
//   misalign          one-cycle pulse: accepted branch_target had [1:0] != 0
//   perf_fetch/_stall/_flush  performance counters
//
// Configuration
//   FETCH_PERF_CNT_EN  when defined, the three perf counters are implemented;
//                      otherwise the perf ports are tied to zero.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
);

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    // Wraps modulo 2^32, so pc = FFFF_FFFC advances to 0.
    assign pc_plus4  = pc + INSTR_BYTES;
    assign imem_addr = pc;

    // Program counter and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= BUBBLE_INSTR;
            if_id_valid <= 1'b0;
            misalign    <= 1'b0;
        end else if (flush) begin
            // Redirect is forced to word alignment; the low bits only raise misalign.
            pc          <= {branch_target[XLEN-1:2], 2'b00};
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_instr <= BUBBLE_INSTR;
            if_id_valid <= 1'b0;
            misalign    <= |branch_target[1:0];
        end else if (stall) begin
            misalign    <= 1'b0;
        end else begin
            pc          <= pc_plus4;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_plus4;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
            misalign    <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Exactly one counter moves per non-reset cycle; a flush never counts as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    assign perf_fetch = fetch_cnt;
    assign perf_stall = stall_cnt;
    assign perf_flush = flush_cnt;
`else
    assign perf_fetch = CNT_W'(0);
    assign perf_stall = CNT_W'(0);
    assign perf_flush = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboarded bench for fetch_stage. Each cycle the stimulus task updates a
// behavioural model of pc / IF/ID and pushes the expected register state; the
// scenario tasks pop and compare it one edge later, plus fixed-value checks.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE   = 32'h0000_0033;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid, misalign;
    logic [31:0] perf_fetch, perf_stall, perf_flush;

    int   cmp  = 0;
    int   errs = 0;
    obs_t sb[$];
    obs_t m;                 // model state (m.addr = pc)
    logic [31:0] m_pf = '0, m_ps = '0, m_pfl = '0;
    obs_t got, exp_o;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .misalign(misalign),
        .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    function automatic logic [95:0] exp_perf();
        return PERF_ON ? {m_pf, m_ps, m_pfl} : 96'h0;
    endfunction

    // Drive one cycle, advance the model, push the expected post-edge state.
    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; flush = f; branch_target = t;
        if (r) begin
            m = '{addr: RESET_PC, pc: 32'h0, pc4: 32'h0, instr: BUBBLE, valid: 1'b0, mis: 1'b0};
            m_pf = '0; m_ps = '0; m_pfl = '0;
        end else if (f) begin
            m = '{addr: {t[31:2], 2'b00}, pc: 32'h0, pc4: 32'h0, instr: BUBBLE,
                  valid: 1'b0, mis: (t[1:0] != 2'b00)};
            m_pfl = m_pfl + 32'd1;
        end else if (s) begin
            m.mis = 1'b0;
            m_ps  = m_ps + 32'd1;
        end else begin
            m = '{addr: m.addr + 32'd4, pc: m.addr, pc4: m.addr + 32'd4,
                  instr: mem_word(m.addr), valid: 1'b1, mis: 1'b0};
            m_pf = m_pf + 32'd1;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
            exp_o = sb.pop_front(); cmp++;
            if (got !== exp_o) begin errs++; $display("FAIL reset[%0d]: got %h want %h", i, got, exp_o); end
        end
        cmp++;
        if ({perf_fetch, perf_stall, perf_flush} !== 96'h0) begin
            errs++; $display("FAIL reset_perf: got %h want 0", {perf_fetch, perf_stall, perf_flush});
        end
    endtask

    task automatic test_advance();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
            exp_o = sb.pop_front(); cmp++;
            if (got !== exp_o) begin errs++; $display("FAIL advance[%0d]: got %h want %h", i, got, exp_o); end
            cmp++;
            if (if_id_pc !== 32'(i * 4) || if_id_valid !== 1'b1) begin
                errs++; $display("FAIL advance_pc[%0d]: got %h/%b want %h/1", i, if_id_pc, if_id_valid, 32'(i * 4));
            end
        end
        cmp++;
        if (perf_fetch !== (PERF_ON ? 32'd4 : 32'd0)) begin
            errs++; $display("FAIL perf_fetch4: got %0d", perf_fetch);
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
            exp_o = sb.pop_front(); cmp++;
            if (got !== exp_o) begin errs++; $display("FAIL stall[%0d]: got %h want %h", i, got, exp_o); end
            cmp++;
            if (if_id_pc !== 32'h8 || imem_addr !== 32'hC) begin
                errs++; $display("FAIL stall_hold[%0d]: pc %h addr %h want 8/c", i, if_id_pc, imem_addr);
            end
        end
        cmp++;
        if (perf_stall !== (PERF_ON ? 32'd3 : 32'd0)) begin
            errs++; $display("FAIL perf_stall3: got %0d", perf_stall);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_pc !== 32'hC) begin
            errs++; $display("FAIL stall_release: got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_flush_over_stall();
        step(1'b0, 1'b1, 1'b1, 32'h40);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h33) begin
            errs++; $display("FAIL flush_bubble: got %h want %h", got, exp_o);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_pc !== 32'h40 || if_id_valid !== 1'b1) begin
            errs++; $display("FAIL flush_target: got %h want %h", got, exp_o);
        end
        cmp++;
        if ({perf_fetch, perf_stall, perf_flush} !== exp_perf()) begin
            errs++; $display("FAIL flush_perf: got %h want %h", {perf_fetch, perf_stall, perf_flush}, exp_perf());
        end
    endtask

    task automatic test_misalign();
        step(1'b0, 1'b0, 1'b1, 32'h42);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || imem_addr !== 32'h40 || misalign !== 1'b1) begin
            errs++; $display("FAIL misalign_set: got %h want %h", got, exp_o);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || misalign !== 1'b0) begin
            errs++; $display("FAIL misalign_clear: got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        void'(sb.pop_front());
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin
            errs++; $display("FAIL wrap_top: got %h want %h", got, exp_o);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_pc !== 32'h0) begin
            errs++; $display("FAIL wrap_zero: got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 1'b1, 32'h100);
        void'(sb.pop_front());
        step(1'b0, 1'b0, 1'b1, 32'h200);
        void'(sb.pop_front());
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_pc !== 32'h200 || imem_addr !== 32'h204) begin
            errs++; $display("FAIL b2b_flush: got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        void'(sb.pop_front());
        step(1'b1, 1'b1, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || imem_addr !== RESET_PC || if_id_valid !== 1'b0) begin
            errs++; $display("FAIL rst_over_stall: got %h want %h", got, exp_o);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        void'(sb.pop_front());
        step(1'b1, 1'b0, 1'b1, 32'h80);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || imem_addr !== RESET_PC || if_id_valid !== 1'b0) begin
            errs++; $display("FAIL rst_over_flush: got %h want %h", got, exp_o);
        end
        cmp++;
        if ({perf_fetch, perf_stall, perf_flush} !== 96'h0) begin
            errs++; $display("FAIL rst_perf: got %h want 0", {perf_fetch, perf_stall, perf_flush});
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
        exp_o = sb.pop_front(); cmp++;
        if (got !== exp_o || if_id_instr !== mem_word(RESET_PC) || if_id_valid !== 1'b1) begin
            errs++; $display("FAIL first_after_rst: got %h want %h", got, exp_o);
        end
    endtask

    task automatic test_random();
        logic s, f;
        logic [31:0] t;
        for (int i = 0; i < 200; i++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 6) == 0);
            t = $urandom();
            step(1'b0, s, f, t);
            got = {imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misalign};
            exp_o = sb.pop_front(); cmp++;
            if (got !== exp_o) begin errs++; $display("FAIL random[%0d]: got %h want %h", i, got, exp_o); end
            cmp++;
            if ({perf_fetch, perf_stall, perf_flush} !== exp_perf()) begin
                errs++; $display("FAIL random_perf[%0d]: got %h want %h", i,
                                 {perf_fetch, perf_stall, perf_flush}, exp_perf());
            end
        end
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_flush_over_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, drives the address of the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. The hazard unit supplies stall requests and the branch-resolution logic supplies flush and redirect requests. The block sits directly upstream of the instruction memory and feeds the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BUBBLE_INSTR, 32'h0000_0033, word injected into IF/ID on reset/flush (add x0,x0,x0)
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  redirect PC to branch_target and kill the in-flight fetch
- branch_target  in  32  redirect address, sampled only when flush=1
- imem_addr  out  32  byte address to instruction memory; equals pc
- imem_data  in  32  instruction word from memory, combinational on imem_addr
- if_id_pc  out  32  PC of the instruction held in IF/ID
- if_id_pc4  out  32  if_id_pc + 4
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  1 = real instruction, 0 = bubble
- misalign  out  1  one-cycle pulse: accepted branch_target had [1:0] != 0
- perf_fetch  out  32  count of instructions captured with valid=1
- perf_stall  out  32  count of stall cycles (stall=1, flush=0)
- perf_flush  out  32  count of flush cycles

## Operation
- pc is an internal 32-bit register; imem_addr = pc combinationally.
- Per rising edge, priority: rst > flush > stall > advance.
- rst: pc <= RESET_PC; if_id_pc/if_id_pc4 <= 0; if_id_instr <= BUBBLE_INSTR; if_id_valid <= 0; misalign <= 0; perf counters <= 0.
- flush (overrides stall): pc <= {branch_target[31:2], 2'b00}; IF/ID loads bubble (pc fields 0, BUBBLE_INSTR, valid 0); misalign <= |branch_target[1:0].
- stall (flush=0): pc and all IF/ID fields hold; misalign <= 0.
- advance: pc <= pc + 4; IF/ID <= {pc, pc+4, imem_data, valid=1}; misalign <= 0.
- pc + 4 is mod 2^32: pc = 32'hFFFF_FFFC advances to 0; if_id_pc4 wraps the same way.
- Outputs are pure register outputs; no combinational path from any input to if_id_* or misalign.

## Timing
- Fetch latency: word addressed by pc in cycle N appears on if_id_instr after edge N, valid in cycle N+1.
- Branch penalty: flush in cycle N -> cycle N+1 pc = target, IF/ID bubble; cycle N+2 IF/ID holds target instruction (valid 1). Exactly one bubble per flush from this stage.
- Stall of k cycles holds IF/ID for k cycles; no instruction is lost or duplicated.
- Back-to-back flushes: each redirect takes effect; only the last target survives.
- rst asserted mid-stall or coincident with flush: reset wins; next cycle pc = RESET_PC, valid 0.
- First valid instruction after reset release: reset deasserted before edge N -> IF/ID holds Mem[RESET_PC/4] after edge N.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_fetch/perf_stall/perf_flush increment per the rules above, wrap at 2^32, cleared by rst; a flush cycle increments perf_flush only.
- Undefined: counter registers not instantiated; the three perf ports remain and are tied to 32'h0. All other behaviour identical.

## Test plan
- Reset then run 4 cycles with RESET_PC=0, stall/flush low -> if_id_pc = 0,4,8,12 with valid=1; perf_fetch=4 (macro on).
- Stall for 3 cycles while IF/ID holds pc 8 -> if_id_pc stays 8, imem_addr stays 12, perf_stall=3; release -> if_id_pc 12 next.
- flush with branch_target=32'h40 while stall=1 -> next cycle imem_addr=32'h40, if_id_valid=0, if_id_instr=32'h0000_0033; following cycle if_id_pc=32'h40, valid=1.
- flush with branch_target=32'h42 -> pc=32'h40, misalign=1 for exactly one cycle.
- RESET_PC=32'hFFFF_FFFC, run 2 cycles -> if_id_pc=32'hFFFF_FFFC, if_id_pc4=0, then if_id_pc=0.
- Assert rst together with flush (target 32'h80) -> pc=RESET_PC, valid=0, all perf counters 0; compile without FETCH_PERF_CNT_EN -> perf ports read 0 throughout.
